// File: rtl/exe_mem_pipe_reg_pkg.sv
// exe_mem_pipe_reg_pkg
//   Shared definitions for the EXE/MEM pipeline register:
//   - default payload widths (32-bit data, 4-bit destination)
//   - ctrl_t: the three MEM/WB control bits
//   - exe_mem_payload_t: full payload at the default widths
//   - encoding of the stage state reported on state_dbg
package exe_mem_pipe_reg_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEST_W_DEF = 4;

    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef struct packed {
        ctrl_t                   ctrl;
        logic [DATA_W_DEF-1:0]   alu_result;
        logic [DATA_W_DEF-1:0]   val_rm;
        logic [DEST_W_DEF-1:0]   dest;
    } exe_mem_payload_t;

    // Stage state as seen on state_dbg (numerically equal to occupancy).
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/exe_mem_pipe_reg_slot.sv
// pipe_slot
//   One valid bit plus a W-bit payload register.
//   Ports:
//     clk, rst   : rising-edge clock, asynchronous active-low reset
//     load       : capture d_in and mark the slot valid
//     clear      : mark the slot empty (wins over load); payload is held
//     d_in       : payload to capture
//     valid/data : registered slot contents
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d_in,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d,  data_q;

    // Clearing only drops the valid bit so the payload keeps its last value.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// exe_mem_pipe_reg
//   EXE -> MEM pipeline register with valid/ready flow control.
//   SKID=1: head + skid registers, in_ready is purely registered.
//   SKID=0: head register only, in_ready looks through out_ready.
//   Ports:
//     clk, rst                          : clock, async active-low reset
//     flush                             : drop all entries and the current offer
//     in_valid/in_ready + *_in          : upstream (EXE) handshake and payload
//     out_valid/out_ready + outputs     : downstream (MEM) handshake and head payload
//     occupancy                         : number of valid entries (0..2)
//     state_dbg                         : EMPTY/ONE/FULL stage state
//
//   Handshake: a beat moves across an interface on a clock edge where both
//   valid and ready are high (input side additionally requires flush low).
//   A producer holding valid while ready is low keeps its data stable; the
//   stage never captures input while in_ready is low.
module exe_mem_pipe_reg
    import exe_mem_pipe_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_en_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [DATA_W-1:0] ALU_Result_in,
    input  logic [DATA_W-1:0] val_Rm_in,
    input  logic [DEST_W-1:0] Dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WB_en,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] val_Rm,
    output logic [DEST_W-1:0] Dest,
    output logic [1:0]        occupancy,
    output logic [1:0]        state_dbg
);

    localparam int PW = CTRL_W + 2 * DATA_W + DEST_W;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] head_src;
    logic [PW-1:0] head_data;
    logic [PW-1:0] skid_data;
    logic          head_valid;
    logic          skid_valid;
    logic          xfer_in;
    logic          xfer_out;
    logic          head_free;
    logic          head_load;
    logic          head_clear;
    ctrl_t         head_ctrl;

    assign in_pl = {WB_en_in, MEM_R_EN_in, MEM_W_EN_in, ALU_Result_in, val_Rm_in, Dest_in};

    assign xfer_in   = in_valid & in_ready & ~flush;
    assign xfer_out  = head_valid & out_ready;
    // Head can take a new entry this edge if it is empty or being consumed.
    assign head_free = ~head_valid | xfer_out;

    // Skid entry is older than the input, so it refills the head first.
    assign head_src   = skid_valid ? skid_data : in_pl;
    assign head_load  = ~flush & head_free & (skid_valid | xfer_in);
    assign head_clear = flush | (xfer_out & ~skid_valid & ~xfer_in);

    pipe_slot #(.W(PW)) u_head (
        .clk   (clk),
        .rst   (rst),
        .load  (head_load),
        .clear (head_clear),
        .d_in  (head_src),
        .valid (head_valid),
        .data  (head_data)
    );

    generate
        if (SKID) begin : g_skid
            logic skid_load;
            logic skid_clear;

            // Ready depends only on the skid flop, cutting the out_ready path.
            assign in_ready   = ~skid_valid;
            // Accepted input parks in skid only when the head is stalled.
            assign skid_load  = xfer_in & ~head_free;
            assign skid_clear = flush | (skid_valid & xfer_out);

            pipe_slot #(.W(PW)) u_skid (
                .clk   (clk),
                .rst   (rst),
                .load  (skid_load),
                .clear (skid_clear),
                .d_in  (in_pl),
                .valid (skid_valid),
                .data  (skid_data)
            );
        end else begin : g_no_skid
            assign in_ready   = ~head_valid | out_ready;
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
        end
    endgenerate

    assign head_ctrl  = head_data[PW-1 -: CTRL_W];

    assign out_valid  = head_valid;
    // Control bits are masked during bubbles; data fields just hold.
    assign WB_en      = head_valid & head_ctrl.wb_en;
    assign MEM_R_EN   = head_valid & head_ctrl.mem_r_en;
    assign MEM_W_EN   = head_valid & head_ctrl.mem_w_en;
    assign ALU_result = head_data[2*DATA_W+DEST_W-1 -: DATA_W];
    assign val_Rm     = head_data[DATA_W+DEST_W-1 -: DATA_W];
    assign Dest       = head_data[DEST_W-1:0];

    assign occupancy  = {1'b0, head_valid} + {1'b0, skid_valid};
    assign state_dbg  = skid_valid ? ST_FULL : (head_valid ? ST_ONE : ST_EMPTY);

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// tb_exe_mem_pipe_reg
//   Drives one SKID=1 and one SKID=0 instance with the same input stream.
//   Each instance has its own reference FIFO model (capacity 2 or 1).
module tb_exe_mem_pipe_reg;
    import exe_mem_pipe_reg_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- stimulus ----------------
    logic             flush;
    logic             in_valid;
    logic             out_ready;
    exe_mem_payload_t in_pl;

    // ---------------- DUT outputs (index 0: SKID=0, 1: SKID=1) ----------------
    logic [1:0]  o_in_ready, o_valid, o_wb, o_mr, o_mw;
    logic [31:0] o_alu [2];
    logic [31:0] o_vrm [2];
    logic [3:0]  o_dest [2];
    logic [1:0]  o_occ [2];
    logic [1:0]  o_st [2];

    exe_mem_pipe_reg #(.DATA_W(32), .DEST_W(4), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(o_in_ready[0]),
        .WB_en_in(in_pl.ctrl.wb_en), .MEM_R_EN_in(in_pl.ctrl.mem_r_en),
        .MEM_W_EN_in(in_pl.ctrl.mem_w_en),
        .ALU_Result_in(in_pl.alu_result), .val_Rm_in(in_pl.val_rm), .Dest_in(in_pl.dest),
        .out_valid(o_valid[0]), .out_ready(out_ready),
        .WB_en(o_wb[0]), .MEM_R_EN(o_mr[0]), .MEM_W_EN(o_mw[0]),
        .ALU_result(o_alu[0]), .val_Rm(o_vrm[0]), .Dest(o_dest[0]),
        .occupancy(o_occ[0]), .state_dbg(o_st[0])
    );

    exe_mem_pipe_reg #(.DATA_W(32), .DEST_W(4), .SKID(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(o_in_ready[1]),
        .WB_en_in(in_pl.ctrl.wb_en), .MEM_R_EN_in(in_pl.ctrl.mem_r_en),
        .MEM_W_EN_in(in_pl.ctrl.mem_w_en),
        .ALU_Result_in(in_pl.alu_result), .val_Rm_in(in_pl.val_rm), .Dest_in(in_pl.dest),
        .out_valid(o_valid[1]), .out_ready(out_ready),
        .WB_en(o_wb[1]), .MEM_R_EN(o_mr[1]), .MEM_W_EN(o_mw[1]),
        .ALU_result(o_alu[1]), .val_Rm(o_vrm[1]), .Dest(o_dest[1]),
        .occupancy(o_occ[1]), .state_dbg(o_st[1])
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_bad    = 0;

    exe_mem_payload_t m_ent  [2][2];  // FIFO contents, [dut][slot], slot 0 = oldest
    int               m_cnt  [2];
    exe_mem_payload_t m_last [2];     // payload last presented at the head

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready(input int b);
        if (b == 1) return m_cnt[b] < 2;
        return (m_cnt[b] == 0) || out_ready;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_cnt[b]  = 0;
            m_last[b] = '0;
        end
    endtask

    // Apply one clock edge to the model using the inputs present at the edge.
    task automatic model_edge();
        for (int b = 0; b < 2; b++) begin
            bit rdy;
            rdy = model_ready(b);
            if (flush) begin
                m_cnt[b] = 0;
            end else begin
                if (m_cnt[b] > 0 && out_ready) begin
                    m_ent[b][0] = m_ent[b][1];
                    m_cnt[b]--;
                end
                if (in_valid && rdy) begin
                    m_ent[b][m_cnt[b]] = in_pl;
                    m_cnt[b]++;
                end
            end
            if (m_cnt[b] > 0) m_last[b] = m_ent[b][0];
        end
    endtask

    task automatic check_outputs();
        for (int b = 0; b < 2; b++) begin
            bit v;
            v = (m_cnt[b] > 0);
            check($sformatf("d%0d_in_ready", b), 64'(o_in_ready[b]), 64'(model_ready(b)));
            check($sformatf("d%0d_out_valid", b), 64'(o_valid[b]), 64'(v));
            check($sformatf("d%0d_occupancy", b), 64'(o_occ[b]), 64'(m_cnt[b]));
            check($sformatf("d%0d_state", b), 64'(o_st[b]), 64'(m_cnt[b]));
            check($sformatf("d%0d_wb_en", b), 64'(o_wb[b]), 64'(v & m_last[b].ctrl.wb_en));
            check($sformatf("d%0d_mem_r_en", b), 64'(o_mr[b]), 64'(v & m_last[b].ctrl.mem_r_en));
            check($sformatf("d%0d_mem_w_en", b), 64'(o_mw[b]), 64'(v & m_last[b].ctrl.mem_w_en));
            check($sformatf("d%0d_alu", b), 64'(o_alu[b]), 64'(m_last[b].alu_result));
            check($sformatf("d%0d_val_rm", b), 64'(o_vrm[b]), 64'(m_last[b].val_rm));
            check($sformatf("d%0d_dest", b), 64'(o_dest[b]), 64'(m_last[b].dest));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called 1 time unit after a rising edge; inputs must already be set.
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] alu, input bit rdy, input bit fl);
        in_valid             = v;
        out_ready            = rdy;
        flush                = fl;
        in_pl.ctrl           = ctrl_t'(3'($urandom_range(0, 7)));
        in_pl.alu_result     = alu;
        in_pl.val_rm         = $urandom;
        in_pl.dest           = 4'($urandom_range(0, 15));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b1;

        // Streaming at full rate: output lags input by one cycle, occupancy stays 1.
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 32'(i), 1'b1, 1'b0);
            step();
            check("stream_occ", 64'(o_occ[1]), 64'd1);
            check("stream_alu", 64'(o_alu[1]), 64'(i));
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();

        // Backpressure: A head, B skid, C refused until a slot frees.
        drive(1'b1, 32'hA, 1'b0, 1'b0); step();
        drive(1'b1, 32'hB, 1'b0, 1'b0); step();
        check("bp_full_occ", 64'(o_occ[1]), 64'd2);
        check("bp_in_ready", 64'(o_in_ready[1]), 64'd0);
        check("bp_head", 64'(o_alu[1]), 64'hA);
        drive(1'b1, 32'hC, 1'b0, 1'b0); step(); step();
        check("bp_c_not_taken", 64'(o_occ[1]), 64'd2);
        out_ready = 1'b1; step();
        check("bp_second", 64'(o_alu[1]), 64'hB);
        step();
        check("bp_third", 64'(o_alu[1]), 64'hC);
        in_valid = 1'b0; step(); step();

        // Flush collision while full: D must never appear.
        drive(1'b1, 32'h1, 1'b0, 1'b0); step();
        drive(1'b1, 32'h2, 1'b0, 1'b0); step();
        drive(1'b1, 32'hD, 1'b0, 1'b1); step();
        check("flush_occ", 64'(o_occ[1]), 64'd0);
        check("flush_valid", 64'(o_valid[1]), 64'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_no_d", 64'(o_alu[1] == 32'hD), 64'd0);
        end

        // Bubble gating: MEM_W_EN_in high without in_valid stays invisible.
        drive(1'b1, 32'h77, 1'b1, 1'b0); step();
        drive(1'b0, 32'h99, 1'b1, 1'b0);
        in_pl.ctrl.mem_w_en = 1'b1;
        step(); step();
        check("bubble_mem_w_en", 64'(o_mw[1]), 64'd0);
        check("bubble_alu_hold", 64'(o_alu[1]), 64'h77);

        // SKID=0 instance: holding 5 blocks input, consume-and-refill takes 6.
        drive(1'b1, 32'h5, 1'b0, 1'b0); step();
        in_valid = 1'b0; step();
        check("s0_in_ready", 64'(o_in_ready[0]), 64'd0);
        drive(1'b1, 32'h6, 1'b1, 1'b0); step();
        check("s0_head6", 64'(o_alu[0]), 64'h6);
        check("s0_valid6", 64'(o_valid[0]), 64'd1);
        check("s0_occ", 64'(o_occ[0]), 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0); step(); step();

        // Reset mid-stream with two entries held.
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        in_pl.ctrl.wb_en = 1'b1;
        step();
        drive(1'b1, 32'h22, 1'b0, 1'b0); step();
        in_valid = 1'b0;
        check("rst_pre_occ", 64'(o_occ[1]), 64'd2);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(o_valid[1]), 64'd0);
        check("rst_wb_en", 64'(o_wb[1]), 64'd0);
        check("rst_occ", 64'(o_occ[1]), 64'd0);
        check("rst_alu", 64'(o_alu[1]), 64'd0);
        check("rst_in_ready", 64'(o_in_ready[1]), 64'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 19) == 0));
            step();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step(); step();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/exe_mem_pipe_reg.md
EXE_MEM_PIPE_REG -- requirements
Module: exe_mem_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of ALU_result and val_Rm.
REQ-002 SHALL have parameter DEST_W, default 4: width of Dest.
REQ-003 SHALL have parameter SKID, default 1: 1 = two-entry skid buffer, 0 = single register with combinational ready.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port flush  input  1  discards all held entries and the current input.
REQ-007 SHALL have port in_valid  input  1  EXE stage offers an instruction.
REQ-008 SHALL have port in_ready  output  1  stage accepts the offer this cycle.
REQ-009 SHALL have port WB_en_in, MEM_R_EN_in, MEM_W_EN_in  input  1 each  control bits.
REQ-010 SHALL have port ALU_Result_in, val_Rm_in  input  DATA_W each  data payload.
REQ-011 SHALL have port Dest_in  input  DEST_W  destination register.
REQ-012 SHALL have port out_valid  output  1  head entry valid toward MEM.
REQ-013 SHALL have port out_ready  input  1  MEM consumes the head this cycle.
REQ-014 SHALL have port WB_en, MEM_R_EN, MEM_W_EN  output  1 each  head control bits, gated.
REQ-015 SHALL have port ALU_result, val_Rm  output  DATA_W each; Dest  output  DEST_W.
REQ-016 SHALL have port occupancy  output  2  entries held (0..2).

Function
REQ-017 Transfer-in SHALL occur when in_valid & in_ready & ~flush; transfer-out when out_valid & out_ready.
REQ-018 Latency SHALL be 1 cycle: an entry accepted into an empty stage appears at the outputs on the next clk edge.
REQ-019 Output data and controls SHALL come directly from flops (head register), never combinationally from inputs.
REQ-020 WB_en, MEM_R_EN, MEM_W_EN SHALL be 0 whenever out_valid = 0; ALU_result, val_Rm and Dest hold their last values.
REQ-021 SKID=1: in_ready SHALL be ~skid_valid (registered), independent of out_ready in the same cycle.
REQ-022 SKID=1 state: EMPTY (occ 0), ONE (head valid), FULL (head + skid valid).
REQ-023 EMPTY + transfer-in -> ONE; ONE + in-only -> FULL; ONE + out-only -> EMPTY; ONE + in & out -> ONE with new head.
REQ-024 FULL + out -> ONE, the skid entry moves to head; FULL never accepts input (in_ready = 0).
REQ-025 SKID=0: in_ready SHALL be ~out_valid | out_ready; occupancy SHALL never exceed 1.
REQ-026 Ordering SHALL be strict FIFO; no entry is lost or duplicated.
REQ-027 flush SHALL have priority over every transfer: next cycle occupancy = 0, out_valid = 0, input ignored; out_ready that cycle is still a legal consume.
REQ-028 Simultaneous in & out on FULL cannot occur (in_ready = 0); an in_valid held while in_ready = 0 SHALL NOT be captured.
REQ-029 occupancy SHALL equal the number of valid entries, updated on the same edge as the entries.

Reset
REQ-030 Asserting rst (low) SHALL immediately clear all valids, occupancy, control outputs and payload registers to 0, regardless of clk.
REQ-031 Deassertion SHALL leave the stage in EMPTY with in_ready = 1; entries in flight at reset assertion are discarded.

Structure
REQ-032 A shared package SHALL hold the EXE/MEM payload struct (control bits, ALU_result, val_Rm, Dest) and the default widths 32/4.
REQ-033 One sub-module, pipe_slot, SHALL implement a single valid + payload register with load/clear and be instantiated once for head and once for skid (generate on SKID).

Verification
REQ-034 Reset mid-stream: occ=2 with ALU 0x11 and 0x22, pull rst low between edges -> out_valid, WB_en and occupancy = 0 before the next edge.
REQ-035 Streaming: in_valid=1 every cycle with ALU 1,2,3..., out_ready=1 -> out sequence 1,2,3... one cycle late, occupancy constant 1.
REQ-036 Backpressure: out_ready=0 with inputs 0xA, 0xB, 0xC -> 0xA head, 0xB skid, in_ready=0, 0xC not taken; release -> 0xA, 0xB, then 0xC once in_ready = 1.
REQ-037 Flush collision: FULL, flush=1 with in_valid=1 (0xD) -> next cycle occupancy 0, 0xD never appears.
REQ-038 Bubble gating: MEM_W_EN_in=1 with in_valid=0 -> MEM_W_EN stays 0; Dest holds its previous value.
REQ-039 SKID=0 build: out_ready=0 while holding 0x5 -> in_ready=0; out_ready=1 with in_valid=1 (0x6) -> 0x6 head next cycle.
